// File: rtl/trace_defs.sv
// Shared record layout for the writeback trace collector.
// A record is {type, pc, addr, data}: 97 bits, type in the MSB.
package trace_defs;

  localparam logic REC_GRF = 1'b0;
  localparam logic REC_DM  = 1'b1;

  localparam int unsigned REC_W    = 97;
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned ADDR_LSB = 32;
  localparam int unsigned PC_LSB   = 64;
  localparam int unsigned TYPE_BIT = 96;

  typedef logic [REC_W-1:0] rec_t;

  function automatic rec_t pack_rec(input logic rtype, input logic [31:0] pc,
                                    input logic [31:0] addr, input logic [31:0] data);
    return {rtype, pc, addr, data};
  endfunction

endpackage

// File: rtl/trace_fifo2w.sv
// Two-write / one-read FIFO of packed trace records.
// Slot 1 is only written together with slot 0; the caller guarantees there is room.
module trace_fifo2w
  import trace_defs::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr0_en,
  input  rec_t           wr0_data,
  input  logic           wr1_en,
  input  rec_t           wr1_data,
  input  logic           rd_en,
  output rec_t           rd_data,
  output logic           rd_valid,
  output logic [PTR_W:0] count,
  output logic [PTR_W:0] free
);

  localparam logic [PTR_W:0] DepthC = (PTR_W + 1)'(DEPTH);

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_nxt;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       wr_num;
  logic             pop;

  always_comb begin
    pop      = rd_en & rd_valid;
    wr_num   = {1'b0, wr0_en} + {1'b0, wr1_en};
    wptr_nxt = wptr_q + PTR_W'(1);
    wptr_d   = wptr_q + PTR_W'(wr_num);
    rptr_d   = rptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W + 1)'(wr_num) - (PTR_W + 1)'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; rd_valid gates its use downstream.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wptr_q] <= wr0_data;
    if (wr1_en) mem[wptr_nxt] <= wr1_data;
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = mem[rptr_q];
  assign count    = count_q;
  // Room left once this cycle's pop is accounted for.
  assign free     = DepthC - count_q + (PTR_W + 1)'(pop);

endmodule

// File: rtl/wb_trace_collector.sv
// Taps MIPS GRF writes (W stage) and DM stores (M stage) and streams them as ordered records.
// Drops events when the buffer cannot take them, tracking a sticky flag and saturating count.
module wb_trace_collector
  import trace_defs::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grf_we,
  input  logic [31:0] grf_pc,
  input  logic [4:0]  grf_addr,
  input  logic [31:0] grf_wd,
  input  logic        dm_we,
  input  logic [31:0] dm_pc,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wd,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic        rec_type,
  output logic [31:0] rec_pc,
  output logic [31:0] rec_addr,
  output logic [31:0] rec_data,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  rec_t           grf_rec, dm_rec, wr0_data, wr1_data, head;
  logic           grf_ev, dm_ev, wr0_en, wr1_en, fifo_valid;
  logic [PTR_W:0] count, free;
  logic [1:0]     drops;
  logic [16:0]    drop_sum;
  logic           overflow_q, overflow_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;

  // Writes to $0 are architecturally invisible, so they are neither recorded nor dropped.
  assign grf_ev  = grf_we & (grf_addr != 5'd0);
  assign dm_ev   = dm_we;
  assign grf_rec = pack_rec(REC_GRF, grf_pc, {27'd0, grf_addr}, grf_wd);
  assign dm_rec  = pack_rec(REC_DM, dm_pc, dm_addr, dm_wd);

  // The W-stage instruction is older, so GRF always takes slot 0 when present.
  always_comb begin
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_data = grf_rec;
    wr1_data = dm_rec;
    drops    = 2'd0;
    if (grf_ev && dm_ev) begin
      if (free > (PTR_W + 1)'(1)) begin
        wr0_en = 1'b1;
        wr1_en = 1'b1;
      end else if (free != '0) begin
        wr0_en = 1'b1;
        drops  = 2'd1;
      end else begin
        drops  = 2'd2;
      end
    end else if (grf_ev || dm_ev) begin
      if (!grf_ev) wr0_data = dm_rec;
      if (free != '0) wr0_en = 1'b1;
      else            drops  = 2'd1;
    end
  end

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drops};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q | (drops != 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  trace_fifo2w #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr0_en   (wr0_en),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_data (wr1_data),
    .rd_en    (rec_ready),
    .rd_data  (head),
    .rd_valid (fifo_valid),
    .count    (count),
    .free     (free)
  );

  // Head fields read as zero while empty so the outputs match their reset values.
  always_comb begin
    rec_valid = fifo_valid;
    rec_type  = fifo_valid & head[TYPE_BIT];
    rec_pc    = fifo_valid ? head[PC_LSB +: 32] : 32'd0;
    rec_addr  = fifo_valid ? head[ADDR_LSB +: 32] : 32'd0;
    rec_data  = fifo_valid ? head[DATA_LSB +: 32] : 32'd0;
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  logic unused_count;
  assign unused_count = ^count;

endmodule
